// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic_light controller and its monitor.
//   - LIGHT_* : encoding of the 2-bit light bus
//   - ERR_*   : bit positions inside the monitor's err_flags vector
//   - sync_state_t : monitor lock state on the light bus
//   - legal_next() : the only phase allowed to follow a given phase
package traffic_light_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_GREEN   = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b10;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'b11;

  localparam int unsigned ERR_CODE  = 0;
  localparam int unsigned ERR_TRANS = 1;
  localparam int unsigned ERR_SHORT = 2;
  localparam int unsigned ERR_LONG  = 3;

  typedef enum logic {
    ST_UNSYNCED,
    ST_SYNCED
  } sync_state_t;

  function automatic logic [1:0] legal_next(input logic [1:0] cur);
    case (cur)
      LIGHT_RED:    legal_next = LIGHT_GREEN;
      LIGHT_GREEN:  legal_next = LIGHT_YELLOW;
      LIGHT_YELLOW: legal_next = LIGHT_RED;
      default:      legal_next = LIGHT_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Signal bundle between a light-bus source (master) and the monitor (slave).
//   light/en/err_clr : driven by the master side
//   lamp_*, dwell, cycle_count, err_flags, err_pulse : driven by the monitor
interface traffic_light_monitor_if #(
  parameter int unsigned DWELL_W = 5,
  parameter int unsigned CNT_W   = 8
);
  logic [1:0]         light;
  logic               en;
  logic               err_clr;
  logic               lamp_red;
  logic               lamp_yellow;
  logic               lamp_green;
  logic [DWELL_W-1:0] dwell;
  logic [CNT_W-1:0]   cycle_count;
  logic [3:0]         err_flags;
  logic               err_pulse;

  modport master (
    output light, en, err_clr,
    input  lamp_red, lamp_yellow, lamp_green, dwell, cycle_count, err_flags, err_pulse
  );

  modport slave (
    input  light, en, err_clr,
    output lamp_red, lamp_yellow, lamp_green, dwell, cycle_count, err_flags, err_pulse
  );
endinterface

// File: rtl/tl_dwell_counter.sv
// Saturating dwell counter for the light monitor.
//   hold    : freeze count (highest priority)
//   clear   : force count to 0
//   restart : force count to 1 (first cycle of a new phase)
//   count   : current dwell, saturates at all-ones
//   reached : high when this edge moves count onto MAX_DWELL+1
module tl_dwell_counter #(
  parameter int unsigned DWELL_W   = 5,
  parameter int unsigned MAX_DWELL = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hold,
  input  logic               clear,
  input  logic               restart,
  output logic [DWELL_W-1:0] count,
  output logic               reached
);

  logic advance;

  assign advance = !hold && !clear && !restart;
  // Look at the value being left so the flag lines up with count == MAX_DWELL+1.
  assign reached = advance && (count == DWELL_W'(MAX_DWELL));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!hold) begin
      if (clear)             count <= '0;
      else if (restart)      count <= DWELL_W'(1);
      else if (count != '1)  count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker and lamp decoder for the traffic_light controller's light bus.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   mon (slave)  : light/en/err_clr in; one-hot lamps, dwell, cycle_count,
//                  sticky err_flags and err_pulse out
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 2,
  parameter int unsigned MAX_DWELL = 16,
  parameter int unsigned DWELL_W   = 5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  traffic_light_monitor_if.slave  mon
);

  sync_state_t        state, state_n;
  logic [1:0]         light_q;
  logic               first_seg;
  logic [DWELL_W-1:0] dwell;
  logic               reached;
  logic [CNT_W-1:0]   cycle_count;
  logic [3:0]         err_flags;
  logic               err_pulse;
  logic [2:0]         lamps;      // {red, yellow, green}

  logic               load;
  logic               dwell_clear;
  logic               dwell_restart;
  logic               cyc_inc;
  logic [3:0]         err_ev;
  logic [3:0]         err_set;
  logic [2:0]         lamps_n;

  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      LIGHT_RED:    decode = 3'b100;
      LIGHT_YELLOW: decode = 3'b010;
      LIGHT_GREEN:  decode = 3'b001;
      default:      decode = 3'b000;
    endcase
  endfunction

  // Lock state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_UNSYNCED;
    else          state <= state_n;
  end

  // Lock is lost on disable or an illegal code; any legal code (re)acquires it
  always_comb begin
    state_n = state;
    if (!mon.en || mon.light == LIGHT_ILLEGAL) state_n = ST_UNSYNCED;
    else                                       state_n = ST_SYNCED;
  end

  // Per-sample event decode
  always_comb begin
    load          = 1'b0;
    dwell_clear   = 1'b0;
    dwell_restart = 1'b0;
    cyc_inc       = 1'b0;
    err_ev        = '0;
    lamps_n       = lamps;
    if (mon.en) begin
      if (mon.light == LIGHT_ILLEGAL) begin
        err_ev[ERR_CODE] = 1'b1;
        dwell_clear      = 1'b1;
        lamps_n          = '0;
      end else if (state == ST_UNSYNCED) begin
        load          = 1'b1;
        dwell_restart = 1'b1;
        lamps_n       = decode(mon.light);
      end else if (mon.light != light_q) begin
        load          = 1'b1;
        dwell_restart = 1'b1;
        lamps_n       = decode(mon.light);
        if (mon.light != legal_next(light_q))
          err_ev[ERR_TRANS] = 1'b1;
        if (!first_seg && dwell < DWELL_W'(MIN_DWELL))
          err_ev[ERR_SHORT] = 1'b1;
        if (light_q == LIGHT_YELLOW && mon.light == LIGHT_RED)
          cyc_inc = 1'b1;
      end
    end
  end

  // Kept apart from the event decode: reached depends on the counter controls
  always_comb begin
    err_set           = err_ev;
    err_set[ERR_LONG] = err_ev[ERR_LONG] | reached;
  end

  tl_dwell_counter #(
    .DWELL_W   (DWELL_W),
    .MAX_DWELL (MAX_DWELL)
  ) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .hold    (!mon.en),
    .clear   (dwell_clear),
    .restart (dwell_restart),
    .count   (dwell),
    .reached (reached)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      light_q     <= LIGHT_RED;
      first_seg   <= 1'b0;
      cycle_count <= '0;
      err_flags   <= '0;
      err_pulse   <= 1'b0;
      lamps       <= '0;
    end else if (mon.en) begin
      if (load) begin
        light_q   <= mon.light;
        // The segment started by (re)acquiring lock is exempt from the short check
        first_seg <= (state == ST_UNSYNCED);
      end
      if (cyc_inc) cycle_count <= cycle_count + 1'b1;
      err_flags <= (mon.err_clr ? '0 : err_flags) | err_set;
      err_pulse <= |err_set;
      lamps     <= lamps_n;
    end else begin
      err_pulse <= 1'b0;
    end
  end

  assign mon.lamp_red    = lamps[2];
  assign mon.lamp_yellow = lamps[1];
  assign mon.lamp_green  = lamps[0];
  assign mon.dwell       = dwell;
  assign mon.cycle_count = cycle_count;
  assign mon.err_flags   = err_flags;
  assign mon.err_pulse   = err_pulse;

endmodule
